// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush and operand forwarding control
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rb,
  input  logic        id_use_rn,
  input  logic        id_use_rb,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_load,
  input  logic        ex_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN, FLUSHED} state_t;

  state_t      state_q, state_d;
  logic        ex_v_q, ex_rw_q, ex_ld_q;
  logic [4:0]  ex_rd_q;
  logic        mem_v_q, mem_rw_q;
  logic [4:0]  mem_rd_q;
  logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        load_use, br_flush;

  // X31 is the zero register: it never produces a hazard or a forward
  function automatic logic reg_hit(input logic v, input logic rw, input logic [4:0] rd,
                                   input logic [4:0] src, input logic use_src);
    return v && rw && use_src && (rd == src) && (rd != 5'd31);
  endfunction

  assign load_use = id_valid && ex_v_q && ex_ld_q &&
                    (reg_hit(ex_v_q, ex_rw_q, ex_rd_q, id_rn, id_use_rn) ||
                     reg_hit(ex_v_q, ex_rw_q, ex_rd_q, id_rb, id_use_rb));
  assign br_flush = (state_q == RUN) && ex_br_taken;

  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (br_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = FLUSHED;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Forward select for the instruction entering EX: current EX becomes EX/MEM, current MEM becomes MEM/WB
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!idex_bubble) begin
      if (reg_hit(ex_v_q, ex_rw_q, ex_rd_q, id_rn, id_use_rn))
        fwd_a_d = 2'b01;
      else if (reg_hit(mem_v_q, mem_rw_q, mem_rd_q, id_rn, id_use_rn))
        fwd_a_d = 2'b10;
      if (reg_hit(ex_v_q, ex_rw_q, ex_rd_q, id_rb, id_use_rb))
        fwd_b_d = 2'b01;
      else if (reg_hit(mem_v_q, mem_rw_q, mem_rd_q, id_rb, id_use_rb))
        fwd_b_d = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RUN;
      ex_v_q      <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_v_q     <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      mem_v_q  <= ex_v_q;
      mem_rw_q <= ex_rw_q;
      mem_rd_q <= ex_rd_q;
      if (idex_bubble) begin
        ex_v_q  <= 1'b0;
        ex_rw_q <= 1'b0;
        ex_ld_q <= 1'b0;
        ex_rd_q <= 5'd0;
      end else begin
        ex_v_q  <= id_valid;
        ex_rw_q <= id_valid && id_regwrite;
        ex_ld_q <= id_valid && id_load;
        ex_rd_q <= id_rd;
      end
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (load_use && !br_flush && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (br_flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed-vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rn, id_rb, id_rd;
  logic        id_use_rn, id_use_rb, id_regwrite, id_load;
  logic        ex_br_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rn(id_rn), .id_rb(id_rb),
    .id_use_rn(id_use_rn), .id_use_rb(id_use_rb),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load),
    .ex_br_taken(ex_br_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rn, input logic urn,
                        input logic [4:0] rb, input logic urb,
                        input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = v; id_rn = rn; id_use_rn = urn; id_rb = rb; id_use_rb = urb;
    id_rd = rd; id_regwrite = rw; id_load = ld;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ex_br_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk("rst_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1100);

    // LDUR X1,[X2] then ADD X2,X1,X3
    reset_n = 1'b1;
    set_id(1, 2, 1, 0, 0, 1, 1, 1);
    chk("ldur_no_stall", {pc_write, ifid_write, idex_bubble}, 3'b110);
    step();
    set_id(1, 1, 1, 3, 1, 2, 1, 0);
    chk("lu_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b0001);
    step();
    chk("lu_stall_cnt", stall_count, 1);
    chk("lu_bubble_fwd_a", fwd_a, 0);
    chk("lu_one_bubble", {pc_write, ifid_write, idex_bubble}, 3'b110);
    step();
    chk("lu_fwd_a_memwb", fwd_a, 2'b10);

    // ADD X1,X5,X6 then SUB X4,X5,X1
    set_id(1, 5, 1, 6, 1, 1, 1, 0);
    step();
    set_id(1, 5, 1, 1, 1, 4, 1, 0);
    chk("alu_no_stall", {pc_write, idex_bubble}, 2'b10);
    step();
    chk("alu_fwd_b_exmem", fwd_b, 2'b01);
    chk("alu_fwd_a_none", fwd_a, 2'b00);

    // two writers of X1, consumer reads X1
    set_id(1, 7, 1, 8, 1, 1, 1, 0);
    step();
    set_id(1, 7, 1, 8, 1, 1, 1, 0);
    step();
    set_id(1, 1, 1, 9, 1, 10, 1, 0);
    step();
    chk("prio_fwd_a_ex", fwd_a, 2'b01);

    // load to X31, reader of X31
    set_id(1, 2, 1, 0, 0, 31, 1, 1);
    step();
    set_id(1, 31, 1, 2, 1, 11, 1, 0);
    chk("xzr_no_stall", {pc_write, idex_bubble}, 2'b10);
    step();
    chk("xzr_fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("xzr_stall_cnt", stall_count, 1);

    // taken branch coincident with load-use
    set_id(1, 2, 1, 0, 0, 3, 1, 1);
    step();
    set_id(1, 3, 1, 0, 0, 12, 1, 0);
    ex_br_taken = 1'b1;
    #1;
    chk("br_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1111);
    step();
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_count, 1);
    chk("flushed_ignore_br", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1100);
    step();
    chk("flushed_flush_cnt", flush_count, 1);
    ex_br_taken = 1'b0;

    // id_valid=0 never stalls
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    step();
    set_id(0, 5, 1, 5, 1, 0, 0, 0);
    chk("invalid_no_stall", {pc_write, idex_bubble}, 2'b10);
    step();

    // reset during a stall cycle
    set_id(1, 2, 1, 0, 0, 4, 1, 1);
    step();
    set_id(1, 4, 1, 0, 0, 13, 1, 0);
    chk("pre_rst_stall", idex_bubble, 1);
    reset_n = 1'b0;
    step();
    chk("rst_mid_cnts", {stall_count, flush_count}, 32'h0);
    chk("rst_mid_fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("rst_mid_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1100);
    reset_n = 1'b1;
    #1;
    chk("post_rst_empty", {pc_write, ifid_write, ifid_flush, idex_bubble}, 4'b1100);
    step();
    chk("post_rst_stall_cnt", stall_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
